// File: rtl/time_mode_engine.sv
// time_mode_engine: wall clock, stopwatch with lap, and countdown with alarm
// sharing one second prescaler, with a registered BCD MM:SS display mux.
module time_mode_engine #(
  parameter int          TICK_DIV     = 50_000_000,
  parameter int          MIN_WRAP     = 60,
  parameter logic [15:0] CD_INIT      = 16'h0950,
  parameter int          ALARM_CYCLES = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic [1:0]  buttonsInput,
  output logic [15:0] big_bin,
  output logic        alarm,
  output logic        tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES + 1) : 1;
  localparam int MM = MIN_WRAP - 1;
  localparam logic [7:0]    M_MAX  = 8'((MM / 10) * 16 + MM % 10);
  localparam logic [15:0]   T_MAX  = {M_MAX, 8'h59};
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] A_LAST = AW'(ALARM_CYCLES - 1);

  typedef enum logic [1:0] {CD_IDLE, CD_RUN, CD_EXP} cd_state_t;

  function automatic logic [7:0] d_inc(input logic [7:0] x);
    return (x[3:0] == 4'd9) ? {x[7:4] + 4'd1, 4'd0} : x + 8'd1;
  endfunction

  function automatic logic [7:0] d_dec(input logic [7:0] x);
    return (x[3:0] == 4'd0) ? {x[7:4] - 4'd1, 4'd9} : x - 8'd1;
  endfunction

  function automatic logic [7:0] m_inc(input logic [7:0] m);
    return (m == M_MAX) ? 8'h00 : d_inc(m);
  endfunction

  function automatic logic [15:0] t_inc(input logic [15:0] t);
    if (t[7:0] == 8'h59)
      return {m_inc(t[15:8]), 8'h00};
    return {t[15:8], d_inc(t[7:0])};
  endfunction

  function automatic logic [15:0] t_dec(input logic [15:0] t);
    if (t[7:0] == 8'h00)
      return {d_dec(t[15:8]), 8'h59};
    return {t[15:8], d_dec(t[7:0])};
  endfunction

  logic [PW-1:0] pcnt;
  logic [1:0]    btn_q, btn_qq, btn_e;
  logic [1:0]    e_clk, e_sw, e_cd;
  logic [15:0]   clk_t, sw_t, lap_t, cd_t, cdt_n;
  logic          sw_run;
  logic [AW-1:0] acnt, acnt_n;
  cd_state_t     cd_st, cd_n;

  assign tick  = (pcnt == P_LAST);
  assign btn_e = btn_q & ~btn_qq;
  assign e_clk = (mode == 2'd0) ? btn_e : 2'b00;
  assign e_sw  = (mode[0]) ? btn_e : 2'b00;
  assign e_cd  = (mode == 2'd2) ? btn_e : 2'b00;

  // one-second prescaler
  always_ff @(posedge clk) begin
    if (rst) pcnt <= '0;
    else     pcnt <= (pcnt == P_LAST) ? '0 : pcnt + PW'(1);
  end

  // button edge detector
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q  <= 2'b00;
      btn_qq <= 2'b00;
    end else begin
      btn_q  <= buttonsInput;
      btn_qq <= btn_q;
    end
  end

  // wall clock: buttons set minutes / zero seconds, else count ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_t <= 16'h0000;
    end else if (|e_clk) begin
      if (e_clk[0]) clk_t[15:8] <= m_inc(clk_t[15:8]);
      if (e_clk[1]) clk_t[7:0]  <= 8'h00;
    end else if (tick) begin
      clk_t <= t_inc(clk_t);
    end
  end

  // stopwatch with lap capture, saturating at the top of the range
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_t   <= 16'h0000;
      lap_t  <= 16'h0000;
      sw_run <= 1'b0;
    end else if (|e_sw) begin
      if (e_sw[0]) sw_run <= ~sw_run;
      if (e_sw[1]) begin
        if (sw_run) begin
          lap_t <= sw_t;
        end else begin
          sw_t  <= 16'h0000;
          lap_t <= 16'h0000;
        end
      end
    end else if (tick && sw_run) begin
      if (sw_t == T_MAX) sw_run <= 1'b0;
      else               sw_t   <= t_inc(sw_t);
    end
  end

  // countdown state, value, alarm length counter and alarm flop
  always_ff @(posedge clk) begin
    if (rst) begin
      cd_st <= CD_IDLE;
      cd_t  <= CD_INIT;
      acnt  <= '0;
      alarm <= 1'b0;
    end else begin
      cd_st <= cd_n;
      cd_t  <= cdt_n;
      acnt  <= acnt_n;
      alarm <= (cd_n == CD_EXP);
    end
  end

  // countdown next state: any edge anywhere silences an expired alarm
  always_comb begin
    cd_n   = cd_st;
    cdt_n  = cd_t;
    acnt_n = acnt;
    unique case (cd_st)
      CD_IDLE: begin
        if (e_cd[0] && cd_t != 16'h0000) cd_n = CD_RUN;
        if (e_cd[1]) cdt_n = CD_INIT;
      end
      CD_RUN: begin
        if (e_cd[0]) begin
          cd_n = CD_IDLE;
        end else if (tick) begin
          cdt_n = t_dec(cd_t);
          if (cdt_n == 16'h0000) begin
            cd_n   = CD_EXP;
            acnt_n = A_LAST;
          end
        end
      end
      CD_EXP: begin
        if ((|btn_e) || acnt == '0) cd_n = CD_IDLE;
        else acnt_n = acnt - AW'(1);
      end
      default: cd_n = CD_IDLE;
    endcase
  end

  // registered display source select
  always_ff @(posedge clk) begin
    if (rst) begin
      big_bin <= 16'h0000;
    end else begin
      unique case (mode)
        2'd0:    big_bin <= clk_t;
        2'd1:    big_bin <= sw_t;
        2'd2:    big_bin <= cd_t;
        default: big_bin <= lap_t;
      endcase
    end
  end

endmodule
